// File: rtl/companion_menu_fsm_if.sv
// ---------------------------------------------------------------------------
// companion_menu_fsm_if
// Bundles the button inputs, the action-engine status and the menu/action
// outputs of companion_menu_fsm.
//   master : drives the raw buttons and exec_status, observes the outputs
//            (board / action-engine side, or a testbench)
//   slave  : the menu controller itself
// Signals:
//   menu_button, next_button, prev_button, select_button : active-low raw
//   exec_status   : 1 = running action finished (synchronous level)
//   selected      : highlighted / executing item code, 0 when closed
//   exec          : high while an action runs
//   menu_open     : high while the menu is shown
//   exec_timeout  : one-cycle pulse, action cut off by the time limit
//   exec_abort    : one-cycle pulse, action cut off by a menu press
// ---------------------------------------------------------------------------
interface companion_menu_fsm_if #(
  parameter int SEL_W = 2
);
  logic             menu_button;
  logic             next_button;
  logic             prev_button;
  logic             select_button;
  logic             exec_status;
  logic [SEL_W-1:0] selected;
  logic             exec;
  logic             menu_open;
  logic             exec_timeout;
  logic             exec_abort;

  modport master (
    output menu_button, next_button, prev_button, select_button, exec_status,
    input  selected, exec, menu_open, exec_timeout, exec_abort
  );

  modport slave (
    input  menu_button, next_button, prev_button, select_button, exec_status,
    output selected, exec, menu_open, exec_timeout, exec_abort
  );
endinterface

// File: rtl/companion_menu_fsm.sv
// ---------------------------------------------------------------------------
// companion_menu_fsm
// Menu/action controller for the companion pet: synchronises the four raw
// buttons, detects presses on their falling edges, moves a cursor over
// NUM_ITEMS actions with wrap-around, runs the chosen action with a
// completion / abort / timeout handshake and closes an idle menu.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : companion_menu_fsm_if.slave (buttons, exec_status, outputs)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | menu closed, selected=0, all buttons except menu ignored
// HOVER | menu shown, cursor moves with next/prev, select starts action
// EXEC  | action running until done, menu press (abort) or timeout
// ---------------------------------------------------------------------------
module companion_menu_fsm #(
  parameter int NUM_ITEMS    = 3,
  parameter int SEL_W        = 2,
  parameter int CNT_W        = 16,
  parameter int EXEC_TIMEOUT = 1000,
  parameter int MENU_TIMEOUT = 0
) (
  input logic                clk,
  input logic                rst,
  companion_menu_fsm_if.slave bus
);

  // Elaboration-time parameter checks
  if (SEL_W < 1 || SEL_W > 30) begin : g_bad_sel_w
    $error("companion_menu_fsm: SEL_W out of range");
  end
  if (NUM_ITEMS < 1 || NUM_ITEMS > (2 ** SEL_W) - 1) begin : g_bad_num_items
    $error("companion_menu_fsm: NUM_ITEMS must be 1..2^SEL_W-1");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("companion_menu_fsm: CNT_W must be 1..32");
  end
  if (EXEC_TIMEOUT < 0 ||
      longint'(EXEC_TIMEOUT) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_exec_tmo
    $error("companion_menu_fsm: EXEC_TIMEOUT does not fit in CNT_W");
  end
  if (MENU_TIMEOUT < 0 ||
      longint'(MENU_TIMEOUT) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_menu_tmo
    $error("companion_menu_fsm: MENU_TIMEOUT does not fit in CNT_W");
  end

  localparam int B_MENU = 3;
  localparam int B_SEL  = 2;
  localparam int B_NEXT = 1;
  localparam int B_PREV = 0;

  localparam logic [SEL_W-1:0] ITEM_FIRST    = SEL_W'(1);
  localparam logic [SEL_W-1:0] ITEM_LAST     = SEL_W'(NUM_ITEMS);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;
  localparam bit               EXEC_TMO_EN   = (EXEC_TIMEOUT != 0);
  localparam bit               MENU_TMO_EN   = (MENU_TIMEOUT != 0);
  // Only meaningful when the matching enable is set
  localparam logic [CNT_W-1:0] EXEC_CNT_LAST = CNT_W'(EXEC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MENU_CNT_LAST = CNT_W'(MENU_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOVER = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  // ---------------- button front end ----------------
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] last_q,  last_d;
  logic [3:0] arm_q,   arm_d;
  logic [1:0] settle_q, settle_d;
  logic [3:0] press;

  assign btn_raw = {bus.menu_button, bus.select_button,
                    bus.next_button, bus.prev_button};

  // The synchroniser reset value of 1 would make a button held through
  // reset look like a fresh falling edge. A button is therefore only armed
  // once real data (settle_q[1]) shows it released at least once.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    last_d   = sync2_q;
    settle_d = {settle_q[0], 1'b1};
    arm_d    = arm_q | ({4{settle_q[1]}} & sync2_q);
    press    = arm_q & ~sync2_q & last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      last_q   <= '1;
      arm_q    <= '0;
      settle_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      last_q   <= last_d;
      arm_q    <= arm_d;
      settle_q <= settle_d;
    end
  end

  // ---------------- state machine ----------------
  state_t           state_q, state_d;
  logic [SEL_W-1:0] cur_q,   cur_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             tmo_q,   tmo_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] cnt_inc;

  // One counter serves as idle counter in HOVER and exec counter in EXEC;
  // it is cleared on every state change.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    abort_d = 1'b0;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        cur_d = '0;
        if (press[B_MENU]) begin
          state_d = ST_HOVER;
          cur_d   = ITEM_FIRST;
        end
      end

      ST_HOVER: begin
        cnt_d = (|press) ? '0 : cnt_inc;
        if (press[B_MENU]) begin
          state_d = ST_IDLE;
          cur_d   = '0;
        end else if (press[B_SEL]) begin
          state_d = ST_EXEC;
        end else if (press[B_NEXT] && !press[B_PREV]) begin
          cur_d = (cur_q == ITEM_LAST) ? ITEM_FIRST : cur_q + ITEM_FIRST;
        end else if (press[B_PREV] && !press[B_NEXT]) begin
          cur_d = (cur_q == ITEM_FIRST) ? ITEM_LAST : cur_q - ITEM_FIRST;
        end else if (MENU_TMO_EN && !(|press) && cnt_q == MENU_CNT_LAST) begin
          state_d = ST_IDLE;
          cur_d   = '0;
          cnt_d   = '0;
        end
      end

      ST_EXEC: begin
        cnt_d = cnt_inc;
        if (bus.exec_status) begin
          state_d = ST_HOVER;
          cnt_d   = '0;
        end else if (press[B_MENU]) begin
          state_d = ST_IDLE;
          cur_d   = '0;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (EXEC_TMO_EN && cnt_q == EXEC_CNT_LAST) begin
          state_d = ST_HOVER;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cur_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      abort_q <= abort_d;
    end
  end

  assign bus.selected     = (state_q == ST_IDLE) ? '0 : cur_q;
  assign bus.exec         = (state_q == ST_EXEC);
  assign bus.menu_open    = (state_q == ST_HOVER);
  assign bus.exec_timeout = tmo_q;
  assign bus.exec_abort   = abort_q;

endmodule

// File: tb/tb_companion_menu_fsm.sv
// ---------------------------------------------------------------------------
// tb_companion_menu_fsm
// Directed stimulus for companion_menu_fsm (NUM_ITEMS=3, EXEC_TIMEOUT=8,
// MENU_TIMEOUT=10). Each stimulus step queues the output vector
// {selected, exec, menu_open, exec_timeout, exec_abort} it should produce
// together with the cycle at which it must appear; a monitor compares every
// change of that vector against the queue head.
// ---------------------------------------------------------------------------
module tb_companion_menu_fsm;

  localparam logic [3:0] M_MENU = 4'b1000;
  localparam logic [3:0] M_SEL  = 4'b0100;
  localparam logic [3:0] M_NEXT = 4'b0010;
  localparam logic [3:0] M_PREV = 4'b0001;

  localparam logic [5:0] V_IDLE  = 6'b00_0000;
  localparam logic [5:0] V_ABORT = 6'b00_0001;

  typedef struct packed {
    int         cyc;
    logic [5:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  companion_menu_fsm_if #(.SEL_W(2)) bus ();

  companion_menu_fsm #(
    .NUM_ITEMS   (3),
    .SEL_W       (2),
    .CNT_W       (16),
    .EXEC_TIMEOUT(8),
    .MENU_TIMEOUT(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] hov(input logic [1:0] s);
    return {s, 4'b0100};
  endfunction
  function automatic logic [5:0] exe(input logic [1:0] s);
    return {s, 4'b1000};
  endfunction
  function automatic logic [5:0] hov_tmo(input logic [1:0] s);
    return {s, 4'b0110};
  endfunction

  task automatic expect_at(input int c, input logic [5:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic drive_buttons(input logic [3:0] m);
    bus.menu_button   = ~m[3];
    bus.select_button = ~m[2];
    bus.next_button   = ~m[1];
    bus.prev_button   = ~m[0];
  endtask

  // Called at a falling edge with cyc=c: the press changes the outputs at
  // rising edge c+3 (sample at c+1, sync2 at c+2, state at c+3).
  task automatic press(input logic [3:0] m, input bit chg, input logic [5:0] v);
    if (chg) expect_at(cyc + 3, v);
    drive_buttons(m);
    @(negedge clk);
    drive_buttons(4'b0000);
    @(negedge clk);
  endtask

  // Monitor: every change of the output vector must match the queue head.
  initial begin
    logic [5:0] prev;
    logic [5:0] curv;
    bit         have;
    exp_t       e;
    have = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      curv = {bus.selected, bus.exec, bus.menu_open, bus.exec_timeout, bus.exec_abort};
      if (!have || curv != prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change cyc=%0d got=%b want=no_change", cyc, curv);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc == cyc && e.vec == curv)
            n_pass++;
          else
            $display("FAIL out_change cyc=%0d got=%b want=%b at cyc %0d",
                     cyc, curv, e.vec, e.cyc);
        end
      end
      have = 1'b1;
      prev = curv;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    rst = 1'b1;
    drive_buttons(4'b0000);
    bus.exec_status = 1'b0;
    expect_at(1, V_IDLE);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // open, wrap forward, prev wrap, simultaneous presses
    press(M_MENU, 1, hov(2'd1));
    press(M_NEXT, 1, hov(2'd2));
    press(M_NEXT, 1, hov(2'd3));
    press(M_NEXT, 1, hov(2'd1));
    press(M_PREV, 1, hov(2'd3));
    press(M_NEXT | M_PREV, 0, V_IDLE);
    press(M_MENU | M_SEL, 1, V_IDLE);
    press(M_NEXT, 0, V_IDLE);

    // exec completion after 5 cycles
    press(M_MENU, 1, hov(2'd1));
    press(M_NEXT, 1, hov(2'd2));
    s = cyc + 3;
    press(M_SEL, 1, exe(2'd2));
    while (cyc < s + 4) @(negedge clk);
    bus.exec_status = 1'b1;
    expect_at(cyc + 1, hov(2'd2));
    @(negedge clk);
    bus.exec_status = 1'b0;

    // exec timeout: exactly 8 exec cycles, then one-cycle pulse
    s = cyc + 3;
    press(M_SEL, 1, exe(2'd2));
    expect_at(s + 8, hov_tmo(2'd2));
    expect_at(s + 9, hov(2'd2));
    while (cyc < s + 9) @(negedge clk);

    // completion coinciding with timeout: no pulse
    s = cyc + 3;
    press(M_SEL, 1, exe(2'd2));
    expect_at(s + 8, hov(2'd2));
    while (cyc < s + 7) @(negedge clk);
    bus.exec_status = 1'b1;
    @(negedge clk);
    bus.exec_status = 1'b0;

    // abort by menu press
    s = cyc + 3;
    press(M_SEL, 1, exe(2'd2));
    press(M_MENU, 1, V_ABORT);
    expect_at(s + 3, V_IDLE);
    while (cyc < s + 3) @(negedge clk);

    // reset mid-EXEC with menu held low across reset release
    press(M_MENU, 1, hov(2'd1));
    s = cyc + 3;
    press(M_SEL, 1, exe(2'd1));
    while (cyc < s + 2) @(negedge clk);
    expect_at(cyc + 1, V_IDLE);
    rst = 1'b1;
    bus.menu_button = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    bus.menu_button = 1'b1;
    repeat (4) @(negedge clk);

    // held next advances once, then the menu auto-closes 10 cycles later
    press(M_MENU, 1, hov(2'd1));
    expect_at(cyc + 3, hov(2'd2));
    expect_at(cyc + 13, V_IDLE);
    bus.next_button = 1'b0;
    repeat (20) @(negedge clk);
    bus.next_button = 1'b1;
    repeat (3) @(negedge clk);

    // untouched menu closes after exactly 10 HOVER cycles
    s = cyc + 3;
    press(M_MENU, 1, hov(2'd1));
    expect_at(s + 10, V_IDLE);
    while (cyc < s + 12) @(negedge clk);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0)
      n_pass++;
    else
      $display("FAIL pending_expectations got=%0d want=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
